// File: rtl/multih_sym_strobe_gen.sv
// Symbol-timing and stimulus sequencer for the multi-h demodulator datapath:
// symbol/half-symbol strobes, rotator select, h-index cycling and PN data.
`timescale 1ns/1ps
module multih_sym_strobe_gen #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned ROT_W        = 5,
  parameter int unsigned H_COUNT      = 2,
  parameter int unsigned H_W          = 2,
  parameter int unsigned PN_W         = 16,
  parameter logic [PN_W-1:0] PN_POLY  = 16'h008e,
  parameter logic [PN_W-1:0] PN_SEED  = 16'h00ff,
  parameter int unsigned ZERO_RUN_MAX = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic             jitterEn,
  output logic             symEn,
  output logic             sym2xEn,
  output logic [ROT_W-1:0] rotSel,
  output logic             rotWrap,
  output logic [H_W-1:0]   hIdx,
  output logic             pnBit,
  output logic             dataBit
);

  localparam int unsigned ZC_W      = 5;
  localparam int unsigned MIN_PER   = 4;

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} stateT;

  stateT             state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [CNT_W-1:0]  periodReg, periodNext;
  logic [PN_W-1:0]   sr, srNext;
  logic [ZC_W-1:0]   zeroCount, zcNext;
  logic [ROT_W-1:0]  rotNext;
  logic [H_W-1:0]    hNext;
  logic              symNext, sym2Next, wrapNext, pnNext, dataNext;
  logic [CNT_W-1:0]  half, lastCnt;

  assign half    = periodReg >> 1;
  assign lastCnt = periodReg - CNT_W'(1);

  // State register: every piece of state, including the registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      cnt       <= '0;
      periodReg <= CNT_W'(MIN_PER);
      sr        <= PN_SEED;
      zeroCount <= '0;
      symEn     <= 1'b0;
      sym2xEn   <= 1'b0;
      rotSel    <= '0;
      rotWrap   <= 1'b0;
      hIdx      <= '0;
      pnBit     <= 1'b0;
      dataBit   <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      periodReg <= periodNext;
      sr        <= srNext;
      zeroCount <= zcNext;
      symEn     <= symNext;
      sym2xEn   <= sym2Next;
      rotSel    <= rotNext;
      rotWrap   <= wrapNext;
      hIdx      <= hNext;
      pnBit     <= pnNext;
      dataBit   <= dataNext;
    end
  end

  // Next-state logic; with enable low everything holds and strobes drop
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    periodNext = periodReg;
    srNext     = sr;
    zcNext     = zeroCount;
    rotNext    = rotSel;
    hNext      = hIdx;
    dataNext   = dataBit;
    pnNext     = pnBit;
    symNext    = 1'b0;
    sym2Next   = 1'b0;
    wrapNext   = 1'b0;

    if (enable) begin
      symNext  = (cnt == '0) && (state == RUN);
      sym2Next = symNext || (cnt == half);

      // Period is only sampled at the symbol boundary
      if (cnt == '0) begin
        periodNext = (period < CNT_W'(MIN_PER)) ? CNT_W'(MIN_PER) : period;
      end

      case (state)
        STALL: begin
          stateNext = RUN;
          cntNext   = '0;
        end
        default: begin
          if (cnt == lastCnt) begin
            if (jitterEn && pnBit) begin
              stateNext = STALL;
            end else begin
              cntNext = '0;
            end
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
      endcase

      if (symNext) begin
        rotNext  = rotSel + ROT_W'(1);
        wrapNext = &rotSel;
        hNext    = (hIdx == H_W'(H_COUNT - 1)) ? '0 : hIdx + H_W'(1);
        dataNext = pnBit;
      end

      // Zero-run limit forces feedback so the register cannot lock up at zero
      if (sr[0] || (zeroCount == ZC_W'(ZERO_RUN_MAX))) begin
        srNext = (sr >> 1) ^ PN_POLY;
        zcNext = '0;
      end else begin
        srNext = sr >> 1;
        zcNext = zeroCount + ZC_W'(1);
      end
      pnNext = sr[0];
    end
  end

endmodule
